// File: rtl/grid_cursor_controller.sv
// grid_cursor_controller
//   Keeps a cursor sprite on a GRID_W x GRID_H tile grid. Buttons step the
//   cursor with a press / hold / auto-repeat timing scheme, and the position
//   wraps at the grid edges. The sprite is composited over the caller's
//   background through a two-stage pixel pipeline that runs alongside a
//   synchronous sprite ROM.
//   Optional feature: define CURSOR_BLINK_EN to make the cursor blink while
//   it is idle.
module grid_cursor_controller #(
  parameter int          GRID_W       = 16,
  parameter int          GRID_H       = 16,
  parameter int          TILE         = 30,
  parameter int          H_ORIGIN     = 144,
  parameter int          V_ORIGIN     = 35,
  parameter logic [11:0] KEY          = 12'hF00,
  parameter int          REPEAT_DELAY = 20,
  parameter int          REPEAT_RATE  = 5,
  parameter int          BLINK_TICKS  = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      move_tick,
  input  logic                      up,
  input  logic                      down,
  input  logic                      left,
  input  logic                      right,
  input  logic                      bright,
  input  logic [9:0]                hCount,
  input  logic [9:0]                vCount,
  input  logic [11:0]               bg_color,
  output logic [$clog2(TILE)-1:0]   rom_row,
  output logic [$clog2(TILE)-1:0]   rom_col,
  input  logic [11:0]               rom_data,
  output logic [$clog2(GRID_W)-1:0] cur_col,
  output logic [$clog2(GRID_H)-1:0] cur_row,
  output logic [11:0]               rgb
);

  localparam int CW   = $clog2(GRID_W);
  localparam int RW   = $clog2(GRID_H);
  localparam int TW   = $clog2(TILE);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int NW   = $clog2(RMAX + 1);

  localparam logic [NW-1:0] DLY_LOAD  = NW'(REPEAT_DELAY - 1);
  localparam logic [NW-1:0] RATE_LOAD = NW'(REPEAT_RATE - 1);

  typedef enum logic [2:0] {D_NONE, D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  dir_t          dir, last_dir, last_dir_n;
  state_t        state, state_n;
  logic [NW-1:0] cnt, cnt_n;
  logic          step;
  logic          show;

  // Highest-priority pressed button wins: right > left > up > down.
  always_comb begin
    dir = D_NONE;
    if (right)      dir = D_RIGHT;
    else if (left)  dir = D_LEFT;
    else if (up)    dir = D_UP;
    else if (down)  dir = D_DOWN;
  end

  // FSM state, repeat counter and the direction the current hold started with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last_dir <= D_NONE;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_dir <= last_dir_n;
    end
  end

  // Next-state logic; everything is frozen between move_ticks.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    last_dir_n = last_dir;
    step       = 1'b0;
    if (move_tick) begin
      case (state)
        S_IDLE: begin
          if (dir != D_NONE) begin
            step       = 1'b1;
            cnt_n      = DLY_LOAD;
            last_dir_n = dir;
            state_n    = S_HOLD;
          end
        end
        S_HOLD, S_REPEAT: begin
          if (dir == D_NONE) begin
            state_n = S_IDLE;
          end else if (dir != last_dir) begin
            // A new direction gets a fresh press: immediate step, full delay.
            step       = 1'b1;
            cnt_n      = DLY_LOAD;
            last_dir_n = dir;
            state_n    = S_HOLD;
          end else if (cnt == '0) begin
            step    = 1'b1;
            cnt_n   = RATE_LOAD;
            state_n = S_REPEAT;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Cursor position; wraps directly between the grid edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_col <= CW'(GRID_W / 2);
      cur_row <= RW'(GRID_H / 2);
    end else if (step) begin
      case (dir)
        D_RIGHT: cur_col <= (cur_col == CW'(GRID_W - 1)) ? '0 : cur_col + 1'b1;
        D_LEFT:  cur_col <= (cur_col == '0) ? CW'(GRID_W - 1) : cur_col - 1'b1;
        D_DOWN:  cur_row <= (cur_row == RW'(GRID_H - 1)) ? '0 : cur_row + 1'b1;
        D_UP:    cur_row <= (cur_row == '0) ? RW'(GRID_H - 1) : cur_row - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS + 1);
  logic [BW-1:0] blink_cnt;

  // Blink phase: toggles every BLINK_TICKS ticks; any step makes it visible again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      show      <= 1'b1;
    end else if (move_tick) begin
      if (step) begin
        blink_cnt <= '0;
        show      <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        show      <= ~show;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end
`else
  assign show = 1'b1;
`endif

  // Sprite window for the current pixel (11-bit so the far edge cannot overflow).
  logic [10:0] x0, y0, hc, vc;
  logic        in_spr;

  always_comb begin
    hc      = {1'b0, hCount};
    vc      = {1'b0, vCount};
    x0      = 11'(H_ORIGIN) + 11'(cur_col) * 11'(TILE);
    y0      = 11'(V_ORIGIN) + 11'(cur_row) * 11'(TILE);
    in_spr  = (hc >= x0) && (hc <= x0 + 11'(TILE - 1)) &&
              (vc >= y0) && (vc <= y0 + 11'(TILE - 1));
    rom_col = in_spr ? TW'(hc - x0) : '0;
    rom_row = in_spr ? TW'(vc - y0) : '0;
  end

  // Stage 1: hold pixel context while the ROM read is in flight.
  logic        in_spr_d, bright_d;
  logic [11:0] bg_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_spr_d <= 1'b0;
      bright_d <= 1'b0;
      bg_d     <= '0;
    end else begin
      in_spr_d <= in_spr;
      bright_d <= bright;
      bg_d     <= bg_color;
    end
  end

  // Stage 2: blank outside the visible area, key out transparent sprite pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rgb <= '0;
    else if (!bright_d)
      rgb <= '0;
    else if (in_spr_d && show && rom_data != KEY)
      rgb <= rom_data;
    else
      rgb <= bg_d;
  end

endmodule

// File: tb/tb_grid_cursor_controller.sv
// Bench for grid_cursor_controller: movement sequences checked per tick,
// pixel path checked from a vector table through an expected-value queue.
module tb_grid_cursor_controller;

  logic        clk = 1'b0, rst = 1'b1, move_tick = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic        bright = 1'b0;
  logic [9:0]  hCount = '0, vCount = '0;
  logic [11:0] bg_color = '0, rom_data = '0;
  logic [4:0]  rom_row, rom_col;
  logic [3:0]  cur_col, cur_row;
  logic [11:0] rgb;

  int n_chk = 0, n_fail = 0;
  logic [11:0] exp_q[$];

  grid_cursor_controller dut (
    .clk(clk), .rst(rst), .move_tick(move_tick),
    .up(up), .down(down), .left(left), .right(right),
    .bright(bright), .hCount(hCount), .vCount(vCount), .bg_color(bg_color),
    .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data),
    .cur_col(cur_col), .cur_row(cur_row), .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  hc, vc;
    logic        br;
    logic [11:0] bg, rom, exp_rgb;
    logic [4:0]  exp_rc, exp_rr;
  } pvec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One move_tick strobe; outputs are sampled on the following negedge.
  task automatic do_tick();
    @(negedge clk); move_tick = 1'b1;
    @(negedge clk); move_tick = 1'b0;
  endtask

  task automatic set_dir(input logic r, input logic l, input logic u, input logic d);
    right = r; left = l; up = u; down = d;
  endtask

  // Press for one tick, release for one tick (returns the FSM to idle).
  task automatic pulse(input logic r, input logic l, input logic u, input logic d);
    set_dir(r, l, u, d); do_tick();
    set_dir(0, 0, 0, 0); do_tick();
  endtask

  // Push one pixel through the pipeline and check it two clocks later.
  task automatic px(input string name, input logic [9:0] h, input logic [9:0] v,
                    input logic b, input logic [11:0] bg, input logic [11:0] rom,
                    input logic [11:0] e);
    logic [11:0] ev;
    @(negedge clk); hCount = h; vCount = v; bright = b; bg_color = bg;
    exp_q.push_back(e);
    @(negedge clk); rom_data = rom; bright = 1'b0;
    @(negedge clk);
    ev = exp_q.pop_front();
    chk(name, rgb, ev);
  endtask

  pvec_t vt[10];

  initial begin
    // Cursor parked at (0,0): sprite spans h 144..173, v 35..64.
    vt[0] = '{10'd144, 10'd35, 1'b1, 12'h123, 12'h0F0, 12'h0F0, 5'd0,  5'd0};
    vt[1] = '{10'd144, 10'd35, 1'b1, 12'h456, 12'hF00, 12'h456, 5'd0,  5'd0};
    vt[2] = '{10'd144, 10'd35, 1'b0, 12'h789, 12'h0F0, 12'h000, 5'd0,  5'd0};
    vt[3] = '{10'd173, 10'd64, 1'b1, 12'h111, 12'hABC, 12'hABC, 5'd29, 5'd29};
    vt[4] = '{10'd174, 10'd64, 1'b1, 12'h222, 12'hABC, 12'h222, 5'd0,  5'd0};
    vt[5] = '{10'd143, 10'd35, 1'b1, 12'h333, 12'hABC, 12'h333, 5'd0,  5'd0};
    vt[6] = '{10'd150, 10'd34, 1'b1, 12'h444, 12'hABC, 12'h444, 5'd0,  5'd0};
    vt[7] = '{10'd150, 10'd40, 1'b1, 12'h555, 12'h5A5, 12'h5A5, 5'd6,  5'd5};
    vt[8] = '{10'd173, 10'd65, 1'b1, 12'h666, 12'hABC, 12'h666, 5'd0,  5'd0};
    vt[9] = '{10'd300, 10'd300, 1'b0, 12'h777, 12'hABC, 12'h000, 5'd0, 5'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_col", cur_col, 8);
    chk("reset_row", cur_row, 8);
    chk("reset_rgb", rgb, 0);
    rst = 1'b0;

    // Single press moves exactly one column
    pulse(1, 0, 0, 0);
    chk("pulse_col", cur_col, 9);
    chk("pulse_row", cur_row, 8);
    do_tick(); do_tick();
    chk("idle_col", cur_col, 9);

    // Held right: steps on ticks 1, 21, 26 only
    set_dir(1, 0, 0, 0);
    for (int t = 1; t <= 30; t++) begin
      do_tick();
      chk($sformatf("hold_t%0d", t), cur_col,
          9 + 1 + ((t >= 21) ? 1 : 0) + ((t >= 26) ? 1 : 0));
    end
    set_dir(0, 0, 0, 0); do_tick();
    chk("hold_end_col", cur_col, 12);

    // Column wrap 15 -> 0
    pulse(1, 0, 0, 0); pulse(1, 0, 0, 0); pulse(1, 0, 0, 0);
    chk("col_15", cur_col, 15);
    pulse(1, 0, 0, 0);
    chk("col_wrap", cur_col, 0);

    // Row wrap 0 -> 15 -> 0
    for (int i = 0; i < 8; i++) pulse(0, 0, 1, 0);
    chk("row_0", cur_row, 0);
    pulse(0, 0, 1, 0);
    chk("row_wrap_up", cur_row, 15);
    pulse(0, 0, 0, 1);
    chk("row_wrap_down", cur_row, 0);

    // right+up: only the column moves; dropping right restarts the hold on up
    set_dir(1, 0, 1, 0); do_tick();
    chk("combo_col", cur_col, 1);
    chk("combo_row", cur_row, 0);
    set_dir(0, 0, 1, 0);
    for (int t = 1; t <= 21; t++) begin
      do_tick();
      chk($sformatf("switch_t%0d", t), cur_row, (t >= 21) ? 14 : 15);
    end
    chk("switch_col", cur_col, 1);
    set_dir(0, 0, 0, 0); do_tick();

    // Park at (0,0)
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
    chk("park_col", cur_col, 0);
    chk("park_row", cur_row, 0);

    // Pixel table: address checked combinationally, rgb checked via the queue
    for (int i = 0; i < 12; i++) begin
      logic [11:0] ev;
      @(negedge clk);
      if (i >= 2) begin
        ev = exp_q.pop_front();
        chk($sformatf("rgb_v%0d", i - 2), rgb, ev);
      end
      if (i >= 1 && i <= 10) rom_data = vt[i-1].rom;
      if (i < 10) begin
        hCount = vt[i].hc; vCount = vt[i].vc; bright = vt[i].br; bg_color = vt[i].bg;
        exp_q.push_back(vt[i].exp_rgb);
        #1;
        chk($sformatf("rom_col_v%0d", i), rom_col, vt[i].exp_rc);
        chk($sformatf("rom_row_v%0d", i), rom_row, vt[i].exp_rr);
      end else begin
        bright = 1'b0;
      end
    end

`ifdef CURSOR_BLINK_EN
    // One idle tick already elapsed since the last step; 14 more hide the sprite.
    for (int i = 0; i < 14; i++) do_tick();
    px("blink_hidden", 10'd144, 10'd35, 1'b1, 12'h0AB, 12'h0F0, 12'h0AB);
    pulse(1, 0, 0, 0);
    px("blink_shown", 10'd174, 10'd35, 1'b1, 12'h0AB, 12'h0F0, 12'h0F0);
`else
    px("show_const", 10'd144, 10'd35, 1'b1, 12'h0AB, 12'h0F0, 12'h0F0);
`endif

    // Reset in the middle of a hold
    px("pre_rst_rgb", 10'd0, 10'd0, 1'b1, 12'hBEE, 12'h000, 12'hBEE);
    set_dir(0, 1, 0, 0); do_tick(); do_tick();
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_mid_col", cur_col, 8);
    chk("rst_mid_row", cur_row, 8);
    chk("rst_mid_rgb", rgb, 0);
    @(negedge clk); rst = 1'b0; set_dir(0, 0, 0, 0);
    pulse(1, 0, 0, 0);
    chk("post_rst_col", cur_col, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop in case something above stalls.
  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
